// File: rtl/hazard_control_unit.sv
// Pipeline hazard / flush controller.
// Drives PC, fetch latch, decode bubbles and operand bypass selects.
module hazard_control_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_EN    = 1,
  parameter int ZERO_REG  = 1,
  parameter int BR_FLUSH  = 2,
  parameter int RET_FLUSH = 2,
  parameter int INT_FLUSH = 2,
  parameter int RST_FLUSH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_read,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         wb_dst,
  input  logic                      wb_wr_en,
  input  logic [3:0]                instr_type,
  input  logic                      branch_taken,
  input  logic                      interrupt,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      fetch_latch_stall,
  output logic                      imem_addr_mux,
  output logic                      dec_nop,
  output logic                      pc_inc,
  output logic                      pc_load,
  output logic                      pc_reset,
  output logic                      flush_active,
  output logic [CNT_W-1:0]          stall_count
);

  typedef enum logic [1:0] {
    S_RESET,
    S_CHECK,
    S_STALL,
    S_FLUSH
  } state_t;

  localparam logic [3:0] BR_LEN  = 4'(BR_FLUSH);
  localparam logic [3:0] RET_LEN = 4'(RET_FLUSH);
  localparam logic [3:0] INT_LEN = 4'(INT_FLUSH);
  localparam logic [3:0] RST_LEN = 4'(RST_FLUSH);

  state_t state_q;
  state_t state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic [NUM_SRC-1:0] ex_hit;
  logic [NUM_SRC-1:0] wb_hit;
  logic [REG_AW-1:0]  addr;

  logic raw_ex;
  logic raw_wb;
  logic raw_stall;
  logic is_br;
  logic is_ret;
  logic in_check;

  // Per-source match against EX/WB and bypass select choice
  always_comb begin
    ex_hit  = '0;
    wb_hit  = '0;
    fwd_sel = '0;
    addr    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr = src_addr[i*REG_AW +: REG_AW];
      ex_hit[i] = src_read[i] && ex_wr_en
                && (addr == ex_dst)
                && !((ZERO_REG != 0) && (addr == '0));
      wb_hit[i] = src_read[i] && wb_wr_en
                && (addr == wb_dst)
                && !((ZERO_REG != 0) && (addr == '0));
      if (FWD_EN != 0) begin
        if (ex_hit[i] && !ex_is_load) begin
          fwd_sel[i*2 +: 2] = 2'b01;
        end else if (wb_hit[i]) begin
          fwd_sel[i*2 +: 2] = 2'b10;
        end
      end
    end
  end

  assign raw_ex = (FWD_EN != 0) ? ((|ex_hit) && ex_is_load)
                                : (|ex_hit);
  assign raw_wb = (FWD_EN != 0) ? 1'b0 : (|wb_hit);
  assign raw_stall = raw_ex || raw_wb;

  assign is_br  = (instr_type >= 4'd1) && (instr_type <= 4'd5);
  assign is_ret = (instr_type >= 4'd6) && (instr_type <= 4'd9);

  // State and flush-length register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= RST_LEN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: interrupt first, then per-state rules
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (interrupt) begin
      state_d = (INT_LEN == 4'd0) ? S_CHECK : S_FLUSH;
      cnt_d   = INT_LEN;
    end else begin
      unique case (state_q)
        S_RESET, S_FLUSH: begin
          if (cnt_q <= 4'd1) begin
            state_d = S_CHECK;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_STALL: begin
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (raw_ex && (FWD_EN == 0)) begin
            state_d = S_STALL;
          end else if (is_br) begin
            state_d = (BR_LEN == 4'd0) ? S_CHECK : S_FLUSH;
            cnt_d   = BR_LEN;
          end else if (is_ret) begin
            state_d = (RET_LEN == 4'd0) ? S_CHECK : S_FLUSH;
            cnt_d   = RET_LEN;
          end
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = RST_LEN;
        end
      endcase
    end
  end

  assign in_check = (state_q == S_CHECK);

  assign fetch_latch_stall = (in_check && raw_stall)
                          || (state_q == S_STALL);
  assign imem_addr_mux = fetch_latch_stall;

  assign dec_nop = (state_q == S_RESET)
                || (state_q == S_FLUSH)
                || fetch_latch_stall
                || (in_check && (is_br || is_ret || interrupt));

  assign pc_reset = !reset;
  assign pc_load  = branch_taken;
  assign pc_inc   = reset && !branch_taken
                 && !fetch_latch_stall
                 && (state_q != S_RESET);

  assign flush_active = (cnt_q != 4'd0);

  // Saturating count of cycles with the fetch latch held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (fetch_latch_stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit.
// Two instances: bypass mode (a) and stall-only mode (b).
module tb_hazard_control_unit;

  typedef struct packed {
    logic [9:0] src_addr;
    logic [1:0] src_read;
    logic [4:0] ex_dst;
    logic       ex_wr_en;
    logic       ex_is_load;
    logic [4:0] wb_dst;
    logic       wb_wr_en;
    logic [3:0] instr_type;
    logic       branch_taken;
    logic       interrupt;
  } in_t;

  typedef struct packed {
    logic [3:0] fsel;
    logic       fls;
    logic       mux;
    logic       nop;
    logic       inc;
    logic       load;
    logic       prst;
    logic       fact;
  } obs_t;

  typedef struct packed {
    logic        dut;
    obs_t        o;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  in_t  in_a;
  in_t  in_b;

  logic [3:0]  a_fsel, b_fsel;
  logic        a_fls, b_fls;
  logic        a_mux, b_mux;
  logic        a_nop, b_nop;
  logic        a_inc, b_inc;
  logic        a_load, b_load;
  logic        a_prst, b_prst;
  logic        a_fact, b_fact;
  logic [15:0] a_cnt, b_cnt;

  exp_t q[$];
  int n_tests;
  int n_fail;

  hazard_control_unit #(.FWD_EN(1)) u_fwd (
    .clk               (clk),
    .reset             (reset),
    .src_addr          (in_a.src_addr),
    .src_read          (in_a.src_read),
    .ex_dst            (in_a.ex_dst),
    .ex_wr_en          (in_a.ex_wr_en),
    .ex_is_load        (in_a.ex_is_load),
    .wb_dst            (in_a.wb_dst),
    .wb_wr_en          (in_a.wb_wr_en),
    .instr_type        (in_a.instr_type),
    .branch_taken      (in_a.branch_taken),
    .interrupt         (in_a.interrupt),
    .fwd_sel           (a_fsel),
    .fetch_latch_stall (a_fls),
    .imem_addr_mux     (a_mux),
    .dec_nop           (a_nop),
    .pc_inc            (a_inc),
    .pc_load           (a_load),
    .pc_reset          (a_prst),
    .flush_active      (a_fact),
    .stall_count       (a_cnt)
  );

  hazard_control_unit #(.FWD_EN(0)) u_nofwd (
    .clk               (clk),
    .reset             (reset),
    .src_addr          (in_b.src_addr),
    .src_read          (in_b.src_read),
    .ex_dst            (in_b.ex_dst),
    .ex_wr_en          (in_b.ex_wr_en),
    .ex_is_load        (in_b.ex_is_load),
    .wb_dst            (in_b.wb_dst),
    .wb_wr_en          (in_b.wb_wr_en),
    .instr_type        (in_b.instr_type),
    .branch_taken      (in_b.branch_taken),
    .interrupt         (in_b.interrupt),
    .fwd_sel           (b_fsel),
    .fetch_latch_stall (b_fls),
    .imem_addr_mux     (b_mux),
    .dec_nop           (b_nop),
    .pc_inc            (b_inc),
    .pc_load           (b_load),
    .pc_reset          (b_prst),
    .flush_active      (b_fact),
    .stall_count       (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t stim(
    logic [4:0] s0, logic [4:0] s1, logic [1:0] rd,
    logic [4:0] exd, logic exw, logic exl,
    logic [4:0] wbd, logic wbw,
    logic [3:0] it, logic bt, logic irq);
    in_t s;
    s.src_addr     = {s1, s0};
    s.src_read     = rd;
    s.ex_dst       = exd;
    s.ex_wr_en     = exw;
    s.ex_is_load   = exl;
    s.wb_dst       = wbd;
    s.wb_wr_en     = wbw;
    s.instr_type   = it;
    s.branch_taken = bt;
    s.interrupt    = irq;
    return s;
  endfunction

  // expected bundle: imem_addr_mux must equal fetch_latch_stall
  function automatic obs_t mk(
    logic [3:0] fsel, logic fls, logic nop, logic inc,
    logic prst, logic fact, logic load);
    obs_t o;
    o.fsel = fsel;
    o.fls  = fls;
    o.mux  = fls;
    o.nop  = nop;
    o.inc  = inc;
    o.load = load;
    o.prst = prst;
    o.fact = fact;
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.fsel = a_fsel;
    o.fls  = a_fls;
    o.mux  = a_mux;
    o.nop  = a_nop;
    o.inc  = a_inc;
    o.load = a_load;
    o.prst = a_prst;
    o.fact = a_fact;
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.fsel = b_fsel;
    o.fls  = b_fls;
    o.mux  = b_mux;
    o.nop  = b_nop;
    o.inc  = b_inc;
    o.load = b_load;
    o.prst = b_prst;
    o.fact = b_fact;
    return o;
  endfunction

  task automatic test_reset();
    in_t s[6];
    logic r[6];
    obs_t xa[6];
    obs_t xb[6];
    exp_t e;
    obs_t got;
    logic [15:0] gc;
    for (int i = 0; i < 6; i++) s[i] = '0;
    s[2] = stim(5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0, 0);
    r = '{0, 0, 0, 1, 1, 1};
    xa[0] = mk(4'b0000, 0, 1, 0, 1, 1, 0);
    xa[1] = mk(4'b0000, 0, 1, 0, 1, 1, 0);
    xa[2] = mk(4'b0001, 0, 1, 0, 1, 1, 0);
    xa[3] = mk(4'b0000, 0, 1, 0, 0, 1, 0);
    xa[4] = mk(4'b0000, 0, 1, 0, 0, 1, 0);
    xa[5] = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    xb = xa;
    xb[2] = mk(4'b0000, 0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      reset = r[i];
      in_a = s[i];
      in_b = s[i];
      e.dut = 0; e.o = xa[i]; e.cnt = 0; q.push_back(e);
      e.dut = 1; e.o = xb[i]; e.cnt = 0; q.push_back(e);
      @(negedge clk);
      repeat (2) begin
        e = q.pop_front();
        got = e.dut ? obs_b() : obs_a();
        gc = e.dut ? b_cnt : a_cnt;
        n_tests++;
        if (got !== e.o || gc !== e.cnt) begin
          n_fail++;
          $display("FAIL reset cyc%0d dut%0d got=%h cnt=%0d exp=%h cnt=%0d",
                   i, e.dut, got, gc, e.o, e.cnt);
        end
      end
    end
  endtask

  task automatic test_forwarding();
    in_t s[8];
    obs_t x[8];
    logic [15:0] c[8];
    exp_t e;
    obs_t got;
    logic [15:0] gc;
    s[0] = stim(5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0, 0);
    s[1] = stim(0, 7, 2'b10, 0, 0, 0, 7, 1, 0, 0, 0);
    s[2] = stim(5, 0, 2'b01, 5, 1, 0, 5, 1, 0, 0, 0);
    s[3] = stim(0, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0);
    s[4] = stim(5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0);
    s[5] = '0;
    s[6] = stim(5, 0, 2'b01, 5, 1, 1, 5, 1, 0, 0, 0);
    s[7] = '0;
    x[0] = mk(4'b0001, 0, 0, 1, 0, 0, 0); c[0] = 0;
    x[1] = mk(4'b1000, 0, 0, 1, 0, 0, 0); c[1] = 0;
    x[2] = mk(4'b0001, 0, 0, 1, 0, 0, 0); c[2] = 0;
    x[3] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[3] = 0;
    x[4] = mk(4'b0000, 1, 1, 0, 0, 0, 0); c[4] = 0;
    x[5] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[5] = 1;
    x[6] = mk(4'b0010, 1, 1, 0, 0, 0, 0); c[6] = 1;
    x[7] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[7] = 2;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_a = s[i];
      e.dut = 0; e.o = x[i]; e.cnt = c[i]; q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      got = obs_a();
      gc = a_cnt;
      n_tests++;
      if (got !== e.o || gc !== e.cnt) begin
        n_fail++;
        $display("FAIL fwd cyc%0d got=%h cnt=%0d exp=%h cnt=%0d",
                 i, got, gc, e.o, e.cnt);
      end
    end
  endtask

  task automatic test_stall_mode();
    in_t s[10];
    obs_t x[10];
    logic [15:0] c[10];
    exp_t e;
    obs_t got;
    logic [15:0] gc;
    s[0] = stim(0, 3, 2'b10, 3, 1, 0, 0, 0, 0, 0, 0);
    s[1] = '0;
    s[2] = '0;
    s[3] = stim(0, 0, 2'b11, 0, 1, 0, 0, 1, 0, 0, 0);
    s[4] = stim(4, 0, 2'b01, 0, 0, 0, 4, 1, 0, 0, 0);
    s[5] = '0;
    s[6] = stim(6, 0, 2'b00, 6, 1, 0, 0, 0, 0, 0, 0);
    s[7] = stim(0, 3, 2'b10, 3, 1, 0, 0, 0, 2, 0, 0);
    s[8] = stim(0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 0, 0);
    s[9] = '0;
    x[0] = mk(4'b0000, 1, 1, 0, 0, 0, 0); c[0] = 0;
    x[1] = mk(4'b0000, 1, 1, 0, 0, 0, 0); c[1] = 1;
    x[2] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[2] = 2;
    x[3] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[3] = 2;
    x[4] = mk(4'b0000, 1, 1, 0, 0, 0, 0); c[4] = 2;
    x[5] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[5] = 3;
    x[6] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[6] = 3;
    x[7] = mk(4'b0000, 1, 1, 0, 0, 0, 0); c[7] = 3;
    x[8] = mk(4'b0000, 1, 1, 0, 0, 0, 0); c[8] = 4;
    x[9] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[9] = 5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_b = s[i];
      e.dut = 1; e.o = x[i]; e.cnt = c[i]; q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      got = obs_b();
      gc = b_cnt;
      n_tests++;
      if (got !== e.o || gc !== e.cnt) begin
        n_fail++;
        $display("FAIL stall cyc%0d got=%h cnt=%0d exp=%h cnt=%0d",
                 i, got, gc, e.o, e.cnt);
      end
    end
  endtask

  task automatic test_branch_flush();
    in_t s[13];
    obs_t x[13];
    exp_t e;
    obs_t got;
    logic [15:0] gc;
    for (int i = 0; i < 13; i++) s[i] = '0;
    s[0] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 1, 0);
    s[4] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd9, 0, 0);
    s[5] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd3, 0, 0);
    s[8] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd10, 0, 0);
    s[9] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd6, 0, 0);
    x[0]  = mk(4'b0000, 0, 1, 0, 0, 0, 1);
    x[1]  = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[2]  = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[3]  = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    x[4]  = mk(4'b0000, 0, 1, 1, 0, 0, 0);
    x[5]  = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[6]  = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[7]  = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    x[8]  = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    x[9]  = mk(4'b0000, 0, 1, 1, 0, 0, 0);
    x[10] = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[11] = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[12] = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      in_a = s[i];
      e.dut = 0; e.o = x[i]; e.cnt = 2; q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      got = obs_a();
      gc = a_cnt;
      n_tests++;
      if (got !== e.o || gc !== e.cnt) begin
        n_fail++;
        $display("FAIL branch cyc%0d got=%h cnt=%0d exp=%h cnt=%0d",
                 i, got, gc, e.o, e.cnt);
      end
    end
  endtask

  task automatic test_interrupt();
    in_t s[9];
    obs_t x[9];
    exp_t e;
    obs_t got;
    logic [15:0] gc;
    for (int i = 0; i < 9; i++) s[i] = '0;
    s[0] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd1, 0, 0);
    s[1] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1);
    s[5] = stim(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1);
    x[0] = mk(4'b0000, 0, 1, 1, 0, 0, 0);
    x[1] = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[2] = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[3] = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[4] = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    x[5] = mk(4'b0000, 0, 1, 1, 0, 0, 0);
    x[6] = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[7] = mk(4'b0000, 0, 1, 1, 0, 1, 0);
    x[8] = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_a = s[i];
      e.dut = 0; e.o = x[i]; e.cnt = 2; q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      got = obs_a();
      gc = a_cnt;
      n_tests++;
      if (got !== e.o || gc !== e.cnt) begin
        n_fail++;
        $display("FAIL irq cyc%0d got=%h cnt=%0d exp=%h cnt=%0d",
                 i, got, gc, e.o, e.cnt);
      end
    end
  endtask

  task automatic test_reset_abort();
    in_t s[5];
    logic r[5];
    obs_t x[5];
    logic [15:0] c[5];
    exp_t e;
    obs_t got;
    logic [15:0] gc;
    for (int i = 0; i < 5; i++) s[i] = '0;
    s[0] = stim(0, 3, 2'b10, 3, 1, 0, 0, 0, 0, 0, 0);
    r = '{1, 0, 1, 1, 1};
    x[0] = mk(4'b0000, 1, 1, 0, 0, 0, 0); c[0] = 5;
    x[1] = mk(4'b0000, 0, 1, 0, 1, 1, 0); c[1] = 0;
    x[2] = mk(4'b0000, 0, 1, 0, 0, 1, 0); c[2] = 0;
    x[3] = mk(4'b0000, 0, 1, 0, 0, 1, 0); c[3] = 0;
    x[4] = mk(4'b0000, 0, 0, 1, 0, 0, 0); c[4] = 0;
    in_a = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      reset = r[i];
      in_b = s[i];
      e.dut = 1; e.o = x[i]; e.cnt = c[i]; q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      got = obs_b();
      gc = b_cnt;
      n_tests++;
      if (got !== e.o || gc !== e.cnt) begin
        n_fail++;
        $display("FAIL abort cyc%0d got=%h cnt=%0d exp=%h cnt=%0d",
                 i, got, gc, e.o, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    obs_t xs;
    obs_t xi;
    exp_t e;
    obs_t got;
    logic [15:0] gc;
    int lens[3];
    in_t s[3];
    lens = '{65534, 70000 - 65534, 2};
    xs = mk(4'b0000, 1, 1, 0, 0, 0, 0);
    xi = mk(4'b0000, 0, 0, 1, 0, 0, 0);
    s[0] = stim(5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0);
    s[1] = s[0];
    s[2] = '0;
    @(posedge clk); #1;
    in_a = s[0];
    e.dut = 0; e.o = xs; e.cnt = 16'd65534; q.push_back(e);
    e.dut = 0; e.o = xs; e.cnt = 16'hFFFF; q.push_back(e);
    e.dut = 0; e.o = xi; e.cnt = 16'hFFFF; q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        @(posedge clk); #1;
        in_a = s[2];
        lens[2] = 1;
      end
      repeat (lens[k]) @(posedge clk);
      @(negedge clk);
      e = q.pop_front();
      got = obs_a();
      gc = a_cnt;
      n_tests++;
      if (got !== e.o || gc !== e.cnt) begin
        n_fail++;
        $display("FAIL saturate step%0d got=%h cnt=%0d exp=%h cnt=%0d",
                 k, got, gc, e.o, e.cnt);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    in_a    = '0;
    in_b    = '0;
    test_reset();
    test_forwarding();
    test_stall_mode();
    test_branch_flush();
    test_interrupt();
    test_reset_abort();
    test_saturation();
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard leftover=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised successor to the pipeline hazard/flush controller; sits between decode, execute and writeback and drives the PC, fetch latch and decode-nop controls.
- Generalises source-operand count, register-address width and per-cause flush lengths.
- Adds an optional forwarding mode, which produces operand-bypass selects and stalls only on load-use.
- Adds a bubble-on-stall rule and a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5: register address width.
- NUM_SRC, 2: source operands checked per decoded instruction.
- FWD_EN, 1: 1 = bypass EX/WB results, stall only on load-use; 0 = stall on any EX/WB RAW.
- ZERO_REG, 1: 1 = register 0 never creates a hazard or a forward.
- BR_FLUSH, 2: extra nop cycles after the branch-detect cycle (0..15).
- RET_FLUSH, 2: extra nop cycles after a return/reti/call detect (0..15).
- INT_FLUSH, 2: extra nop cycles after an interrupt (0..15).
- RST_FLUSH, 2: nop cycles after reset release (1..15).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_addr  in  NUM_SRC*REG_AW  source register addresses; source i = bits [i*REG_AW +: REG_AW].
- src_read  in  NUM_SRC  source i is actually read.
- ex_dst  in  REG_AW  EX-stage destination.
- ex_wr_en  in  1  EX instruction writes ex_dst.
- ex_is_load  in  1  EX instruction is a memory load.
- wb_dst  in  REG_AW  WB-stage destination.
- wb_wr_en  in  1  WB instruction writes wb_dst.
- instr_type  in  4  decode class: 1-5 = branch, 6-9 = call/return.
- branch_taken  in  1  branch resolved taken.
- interrupt  in  1  interrupt request.
- fwd_sel  out  NUM_SRC*2  per source: 00 regfile, 01 EX result, 10 WB result.
- fetch_latch_stall  out  1  hold the fetch/decode latch.
- imem_addr_mux  out  1  re-present the previous instruction-memory address; equals fetch_latch_stall.
- dec_nop  out  1  replace the decode output with a bubble.
- pc_inc  out  1  increment the PC.
- pc_load  out  1  load the PC; equals branch_taken.
- pc_reset  out  1  equals !reset.
- flush_active  out  1  the flush counter is nonzero.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Match rule: source i matches stage X when src_read[i], X_wr_en, and src_addr_i == X_dst. When ZERO_REG=1, addr 0 never matches.
- FWD_EN=1:
  - fwd_sel_i = 01 on an EX match with !ex_is_load.
  - Otherwise fwd_sel_i = 10 on a WB match.
  - Otherwise fwd_sel_i = 00.
  - raw_stall = any source matches EX with ex_is_load.
- FWD_EN=0:
  - fwd_sel is constant 0.
  - raw_stall = any EX or WB match.
- States:
  - RESET: entered asynchronously while reset=0. After release, stays RESET_FLUSH cycles, then goes to CHECK.
  - CHECK: normal operation.
  - STALL: exactly 1 cycle, then back to CHECK.
  - FLUSH: a 4-bit counter counts down to 0, then returns to CHECK.
- Next-state priority, highest first:
  - reset low: RESET.
  - interrupt, from any state: FLUSH with counter = INT_FLUSH. Restarts the counter if already flushing.
  - In CHECK:
    - raw_stall, EX cause, FWD_EN=0: STALL.
    - Else branch class: FLUSH with counter = BR_FLUSH.
    - Else call/return class: FLUSH with counter = RET_FLUSH.
    - A WB-only RAW stalls combinationally and stays in CHECK.
- A zero flush length goes straight back to CHECK.
- Branch or return detection during STALL or FLUSH is ignored, because the instruction is held or discarded.
- Outputs:
  - fetch_latch_stall = imem_addr_mux = (CHECK && raw_stall) || STALL.
  - dec_nop = 1 in RESET, in FLUSH, on any stall cycle (bubble), and in CHECK on a branch, call/return or interrupt detect.
  - pc_inc = !pc_reset && !pc_load && !fetch_latch_stall && state!=RESET.
- stall_count increments on each cycle with fetch_latch_stall=1 and saturates at all-ones.
- Reset values while reset=0:
  - state RESET, counter = RST_FLUSH, stall_count = 0.
  - fetch_latch_stall=0, pc_inc=0, pc_reset=1, dec_nop=1, flush_active=1.
  - fwd_sel keeps following its combinational inputs.
- Reset asserted mid-flush or mid-stall aborts immediately into RESET.

Test Plan:
- Reset low 3 cycles, release → pc_reset 1→0, dec_nop=1 for 2 cycles after release, then pc_inc=1, stall_count=0.
- FWD_EN=1: src0=5 read, ex_dst=5, ex_wr_en=1, ex_is_load=0 → fwd_sel[1:0]=01, no stall. Same stimulus with ex_is_load=1 → fetch_latch_stall=1 for 1 cycle, dec_nop=1, stall_count=1.
- FWD_EN=0: src1=3 read, ex_dst=3 → stall 2 cycles, pc_inc=0 both cycles, stall_count=2. With src=0, ex_dst=0 and ZERO_REG=1 → no stall.
- instr_type=2 in CHECK → dec_nop high 3 consecutive cycles (1+BR_FLUSH), flush_active high on cycles 2-3.
- interrupt in the first FLUSH cycle of a branch flush → counter reloads, dec_nop high for 1+INT_FLUSH cycles from the interrupt.
- Drive 70000 stall cycles with CNT_W=16 → stall_count saturates at 65535.
